// File: rtl/alu_seq32_if.sv
// alu_seq32_if: request/response bus of the 32-bit ALU sequencer (half field only with ALU_SEQ32_HALF_EN)
interface alu_seq32_if;
  logic        req;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        ready, done;
  logic [31:0] result;
  logic        carry, equal;
`ifdef ALU_SEQ32_HALF_EN
  logic        half;
  modport master (output req, op, opa, opb, half, input ready, done, result, carry, equal);
  modport slave (input req, op, opa, opb, half, output ready, done, result, carry, equal);
`else
  modport master (output req, op, opa, opb, input ready, done, result, carry, equal);
  modport slave (input req, op, opa, opb, output ready, done, result, carry, equal);
`endif
endinterface

// File: rtl/alu_seq32.sv
// alu_seq32: two-pass 32-bit sequencer over a 16-bit 74181-style ALU; ALU_SEQ32_HALF_EN adds single-pass 16-bit ops
module alu_seq32 (
  input  logic        clk,
  input  logic        reset,
  alu_seq32_if.slave  bus,
  output logic [3:0]  alu_s,
  output logic        alu_m,
  output logic        alu_cil,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_z,
  input  logic        alu_co,
  input  logic        alu_aeb
);
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  state_t      state;
  logic [2:0]  op;
  logic [31:0] opa, opb;
  logic        chain, lo_eq;
  logic        arith, cmp, use_carry;
`ifdef ALU_SEQ32_HALF_EN
  logic        half;
`endif
  assign cmp = &op;
  assign arith = ~op[2] | cmp;
  assign use_carry = ~op[2] & op[0];
  // ALU port: idle pattern in IDLE, else the half selected by the pass with its function and carry in
  always_comb begin
    alu_a = state == IDLE ? 16'h0 : state == HI ? opa[31:16] : opa[15:0];
    alu_b = state == IDLE ? 16'h0 : state == HI ? opb[31:16] : opb[15:0];
    alu_m = state == IDLE ? 1'b1 : ~arith;
    alu_s = state == IDLE ? 4'b0000 :
            op[2:1] == 2'b00 ? 4'b1001 :
            arith ? 4'b0110 :
            op[1:0] == 2'b00 ? 4'b1011 :
            op[1:0] == 2'b01 ? 4'b1110 : 4'b0110;
    alu_cil = state == HI ? chain :
              state == IDLE || !arith ? 1'b1 :
              use_carry ? ~bus.carry : ~op[1];
  end
  // sequencer: accept, low pass, high pass, registered result and flags
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      bus.ready  <= 1'b1;
      bus.done   <= 1'b0;
      bus.result <= 32'h0;
      bus.carry  <= 1'b0;
      bus.equal  <= 1'b0;
      chain      <= 1'b1;
      lo_eq      <= 1'b0;
      op         <= 3'b000;
      opa        <= 32'h0;
      opb        <= 32'h0;
`ifdef ALU_SEQ32_HALF_EN
      half       <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.req) begin
          op        <= bus.op;
          opa       <= bus.opa;
          opb       <= bus.opb;
`ifdef ALU_SEQ32_HALF_EN
          half      <= bus.half;
`endif
          bus.ready <= 1'b0;
          state     <= LO;
        end
        LO: begin
          chain <= alu_co;
          lo_eq <= alu_aeb;
          if (!cmp) bus.result[15:0] <= alu_z;
          state <= HI;
`ifdef ALU_SEQ32_HALF_EN
          if (half) begin
            if (!cmp) bus.result[31:16] <= 16'h0;
            if (arith) bus.carry <= ~alu_co;
            bus.equal <= alu_aeb;
            bus.done  <= 1'b1;
            bus.ready <= 1'b1;
            state     <= IDLE;
          end
`endif
        end
        HI: begin
          if (!cmp) bus.result[31:16] <= alu_z;
          if (arith) bus.carry <= ~alu_co;
          bus.equal <= lo_eq & alu_aeb;
          bus.done  <= 1'b1;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
endmodule
